host_load_sequencer: RTL and testbench

//   Sequences the tiny-TPU core from a host word stream, replacing hard-coded weights/inputs.

---
 rtl/host_load_sequencer.sv | 140 ++++++++++++++
 tb/tb_host_load_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_load_sequencer.sv
// Host-driven sequencer for the tiny-TPU core: decodes command headers, streams payload
// words into the weight/input buffers, and runs the core with a bounded wait for done.
module host_load_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 6,
   parameter int RUN_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  mem_we,
   output logic                  mem_sel,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  tpu_start,
   input  logic                  tpu_done,
   output logic                  busy,
   output logic                  run_done,
   output logic [1:0]            err
);

   localparam int TW = (RUN_TIMEOUT > 2) ? $clog2(RUN_TIMEOUT) : 1;

   localparam logic [1:0] OP_LOAD_W  = 2'b00;
   localparam logic [1:0] OP_LOAD_I  = 2'b01;
   localparam logic [1:0] OP_RUN     = 2'b10;
   localparam logic [1:0] OP_CLR_ERR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_START = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t                state_r;
   logic                  sel_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] remaining_r;
   logic [TW-1:0]         timer_r;

   logic                  handshake_s;
   logic [1:0]            op_s;
   logic [ADDR_WIDTH-1:0] len_s;

   assign handshake_s = in_valid & in_ready;
   assign op_s        = in_data[DATA_WIDTH-1 -: 2];
   assign len_s       = in_data[ADDR_WIDTH-1:0];

   // Command FSM; every output is registered alongside the state it belongs to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_IDLE;
         sel_r       <= 1'b0;
         addr_r      <= '0;
         remaining_r <= '0;
         timer_r     <= '0;
         in_ready    <= 1'b1;
         mem_we      <= 1'b0;
         mem_sel     <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         tpu_start   <= 1'b0;
         busy        <= 1'b0;
         run_done    <= 1'b0;
         err         <= 2'b00;
      end else begin
         mem_we    <= 1'b0;
         tpu_start <= 1'b0;
         run_done  <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (handshake_s) begin
                  case (op_s)
                     OP_LOAD_W, OP_LOAD_I: begin
                        state_r     <= S_LOAD;
                        sel_r       <= op_s[0];
                        remaining_r <= len_s;
                        addr_r      <= '0;
                        busy        <= 1'b1;
                     end
                     OP_RUN: begin
                        state_r   <= S_START;
                        tpu_start <= 1'b1;
                        timer_r   <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                     end
                     OP_CLR_ERR: err <= 2'b00;
                     default: state_r <= S_IDLE;
                  endcase
               end
            end
            S_LOAD: begin
               // Payload words are written verbatim; the opcode field is never looked at here.
               if (handshake_s) begin
                  mem_we      <= 1'b1;
                  mem_sel     <= sel_r;
                  mem_addr    <= addr_r;
                  mem_wdata   <= in_data;
                  addr_r      <= addr_r + ADDR_WIDTH'(1);
                  remaining_r <= remaining_r - ADDR_WIDTH'(1);
                  if (remaining_r == '0) begin
                     state_r <= S_IDLE;
                     busy    <= 1'b0;
                  end
               end
            end
            S_START: begin
               state_r <= S_WAIT;
               timer_r <= '0;
            end
            S_WAIT: begin
               // Done takes priority over a timeout landing on the same cycle.
               if (tpu_done) begin
                  state_r  <= S_IDLE;
                  run_done <= 1'b1;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else if (timer_r == TW'(RUN_TIMEOUT - 1)) begin
                  state_r  <= S_IDLE;
                  err[1]   <= 1'b1;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            default: begin
               state_r  <= S_IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_host_load_sequencer.sv
// Self-checking bench for host_load_sequencer: randomized loads and runs against a
// cycle-timeline reference derived from the command rules.
module tb_host_load_sequencer;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int RT = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          mem_we;
   logic          mem_sel;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          tpu_start;
   logic          tpu_done;
   logic          busy;
   logic          run_done;
   logic [1:0]    err;

   host_load_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RUN_TIMEOUT(RT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .tpu_start(tpu_start), .tpu_done(tpu_done), .busy(busy), .run_done(run_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t        got_q[$];
   int         got_cyc[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [1:0] err_exp = 2'b00;

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer-write monitor.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         got_q.push_back({mem_sel, mem_addr, mem_wdata});
         got_cyc.push_back(cyc);
      end
   end

   function automatic logic [DW-1:0] hdr(input logic [1:0] op, input logic [AW-1:0] len);
      logic [DW-1:0] h;
      h = DW'($urandom);
      h[DW-1 -: 2] = op;
      h[AW-1:0] = len;
      return h;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present one word and return at the negedge after it was accepted.
   task automatic send(input logic [DW-1:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data = d;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL send_wait: in_ready=%b never rose within 100 cycles, required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data = DW'($urandom);
   endtask

   // Issue RUN and check every cycle against the expected timeline.
   // done_at = WAIT cycle (1-based) on which tpu_done is raised; 0 = never.
   task automatic run_cmd(input int done_at, input bit hold_word);
      int  end_k;
      bit  won;
      int  n;
      won = (done_at >= 1) && (done_at <= RT);
      end_k = won ? done_at + 2 : RT + 2;
      if (!won) err_exp[1] = 1'b1;
      got_q.delete();
      n = 0;
      in_valid = 1'b1;
      in_data = hdr(2'b10, AW'($urandom));
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_valid = hold_word;
      in_data = hdr(2'b00, '0);
      for (int k = 1; k <= end_k; k++) begin
         n_cmp++;
         if (tpu_start !== (k == 1)) begin
            n_bad++;
            $display("FAIL run_tpu_start done_at=%0d k=%0d: got %b want %b", done_at, k, tpu_start, (k == 1));
         end
         n_cmp++;
         if (in_ready !== (k == end_k)) begin
            n_bad++;
            $display("FAIL run_in_ready done_at=%0d k=%0d: got %b want %b", done_at, k, in_ready, (k == end_k));
         end
         n_cmp++;
         if (busy !== (k != end_k)) begin
            n_bad++;
            $display("FAIL run_busy done_at=%0d k=%0d: got %b want %b", done_at, k, busy, (k != end_k));
         end
         n_cmp++;
         if (run_done !== (k == end_k && won)) begin
            n_bad++;
            $display("FAIL run_done done_at=%0d k=%0d: got %b want %b", done_at, k, run_done, (k == end_k && won));
         end
         if (k == end_k) in_valid = 1'b0;
         tpu_done = (done_at > 0) && (k == done_at + 1);
         if (k < end_k) @(negedge clk);
      end
      tpu_done = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if (err !== err_exp) begin
         n_bad++;
         $display("FAIL run_err done_at=%0d: got %b want %b", done_at, err, err_exp);
      end
      n_cmp++;
      if (got_q.size() != 0) begin
         n_bad++;
         $display("FAIL run_no_write done_at=%0d: got %0d writes want 0", done_at, got_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(2);
      n_cmp++;
      if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata, tpu_start, busy, run_done, err} !==
          {1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, 2'b00}) begin
         n_bad++;
         $display("FAIL reset_values: in_ready=%b we=%b sel=%b addr=%h wdata=%h start=%b busy=%b run_done=%b err=%b, want 1,0,0,0,0,0,0,0,00",
                  in_ready, mem_we, mem_sel, mem_addr, mem_wdata, tpu_start, busy, run_done, err);
      end
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_load_w();
      logic [DW-1:0] w [4];
      wr_t exp;
      w = '{16'd11, 16'd22, 16'd33, 16'd44};
      got_q.delete(); got_cyc.delete();
      send(hdr(2'b00, 6'd3));
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL load_w_busy: got %b want 1", busy); end
      for (int i = 0; i < 4; i++) send(w[i]);
      idle(2);
      n_cmp++;
      if (got_q.size() != 4) begin n_bad++; $display("FAIL load_w_count: got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         exp = {1'b0, AW'(i), w[i]};
         n_cmp++;
         if (got_q[i] !== exp) begin n_bad++; $display("FAIL load_w_word%0d: got %h want %h", i, got_q[i], exp); end
         n_cmp++;
         if (got_cyc[i] != got_cyc[0] + i) begin
            n_bad++; $display("FAIL load_w_consec%0d: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i);
         end
      end
      n_cmp++;
      if ({busy, in_ready} !== 2'b01) begin n_bad++; $display("FAIL load_w_idle: busy,in_ready got %b%b want 01", busy, in_ready); end
   endtask

   task automatic test_load_i_gap();
      logic [DW-1:0] w0, w1;
      w0 = DW'($urandom); w1 = DW'($urandom);
      got_q.delete(); got_cyc.delete();
      send(hdr(2'b01, 6'd1));
      send(w0);
      idle(3);
      send(w1);
      idle(2);
      n_cmp++;
      if (got_q.size() != 2) begin n_bad++; $display("FAIL load_i_count: got %0d want 2", got_q.size()); end
      if (got_q.size() == 2) begin
         n_cmp++;
         if (got_q[0] !== {1'b1, 6'd0, w0}) begin n_bad++; $display("FAIL load_i_word0: got %h want %h", got_q[0], {1'b1, 6'd0, w0}); end
         n_cmp++;
         if (got_q[1] !== {1'b1, 6'd1, w1}) begin n_bad++; $display("FAIL load_i_word1: got %h want %h", got_q[1], {1'b1, 6'd1, w1}); end
         n_cmp++;
         if (got_cyc[1] - got_cyc[0] != 4) begin n_bad++; $display("FAIL load_i_gap: got spacing %0d want 4", got_cyc[1] - got_cyc[0]); end
      end
   endtask

   task automatic test_random_loads();
      wr_t           exp_q[$];
      logic          sel;
      logic [AW-1:0] len;
      logic [DW-1:0] d;
      for (int it = 0; it < 6; it++) begin
         sel = 1'($urandom_range(0, 1));
         len = (it == 5) ? {AW{1'b1}} : AW'($urandom_range(0, 9));
         exp_q.delete(); got_q.delete(); got_cyc.delete();
         send(hdr({1'b0, sel}, len));
         for (int i = 0; i <= int'(len); i++) begin
            d = DW'($urandom);
            exp_q.push_back({sel, AW'(i), d});
            idle($urandom_range(0, 2));
            send(d);
         end
         idle(2);
         n_cmp++;
         if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL rand_load%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_load%0d_word%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
         end
         n_cmp++;
         if (busy !== 1'b0) begin n_bad++; $display("FAIL rand_load%0d_busy: got %b want 0", it, busy); end
      end
   endtask

   task automatic test_runs();
      run_cmd(10, 1'b0);
      for (int i = 0; i < 3; i++) run_cmd($urandom_range(1, RT + 4), 1'b1);
   endtask

   task automatic test_timeout_and_clear();
      run_cmd(0, 1'b0);
      run_cmd(5, 1'b0);
      send(hdr(2'b11, AW'($urandom)));
      err_exp = 2'b00;
      n_cmp++;
      if (err !== err_exp) begin n_bad++; $display("FAIL clr_err: got %b want %b", err, err_exp); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_err_busy: got %b want 0", busy); end
   endtask

   task automatic test_done_on_timeout();
      run_cmd(RT, 1'b1);
   endtask

   task automatic test_done_ignored();
      tpu_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         n_cmp++;
         if ({busy, run_done, in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL done_ignored%0d: busy,run_done,in_ready got %b%b%b want 001", i, busy, run_done, in_ready);
         end
      end
      tpu_done = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      run_cmd(0, 1'b0);
      got_q.delete(); got_cyc.delete();
      send(hdr(2'b00, 6'd7));
      send(16'd11);
      send(16'd22);
      #2 reset = 1'b1;
      err_exp = 2'b00;
      #1;
      n_cmp++;
      if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata, tpu_start, busy, run_done, err} !==
          {1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, 2'b00}) begin
         n_bad++;
         $display("FAIL reset_mid_load: in_ready=%b we=%b addr=%h wdata=%h busy=%b err=%b, want 1,0,0,0,0,00",
                  in_ready, mem_we, mem_addr, mem_wdata, busy, err);
      end
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if (got_q.size() != 2) begin n_bad++; $display("FAIL reset_mid_load_writes: got %0d want 2", got_q.size()); end
      run_cmd(3, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      tpu_done = 1'b0;
      @(negedge clk);
      test_reset();
      test_load_w();
      test_load_i_gap();
      test_random_loads();
      test_runs();
      test_timeout_and_clear();
      test_done_on_timeout();
      test_done_ignored();
      test_reset_mid_load();
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
